ecmac_tile_sched: RTL and testbench

Sequencer and output stage for a ROWS x COLS systolic tile of error-compensating MAC cells.
- Runs the per-tile program: weight load, activation stream, drain.
- Gates the array with a global enable and stalls it under output backpressure.
- Applies column-bottom error compensation: adds the forwarded error product to the partial sum whenever a column's error flag is set.
- Sits between the activation/weight buffers and the tile, feeding the accumulator writeback.

---
 rtl/ecmac_pkg.sv | 24 ++
 rtl/ecmac_col_comp.sv | 17 +
 rtl/ecmac_tile_sched.sv | 128 ++++++++++++
 tb/tb_ecmac_tile_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecmac_pkg.sv
// Shared types and helpers for the error-compensating MAC tile scheduler.
package ecmac_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } ecmac_state_t;

    localparam int ACC_W_DEF  = 24;
    localparam int PROD_W_DEF = 16;
    localparam int POP_MAX_W  = 64;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ecmac_col_comp.sv
// Column-bottom compensation: adds the forwarded error product when the column flags an error.
module ecmac_col_comp
    import ecmac_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = PROD_W_DEF
) (
    input  logic [ACC_W-1:0]  psum,
    input  logic [PROD_W-1:0] err_prod,
    input  logic              err,
    output logic [ACC_W-1:0]  res
);

    // Product is unsigned, so zero-extend; the sum wraps modulo 2^ACC_W.
    assign res = psum + (err ? ACC_W'(err_prod) : '0);

endmodule

// File: rtl/ecmac_tile_sched.sv
// Tile sequencer and compensated output stage for a ROWS x COLS systolic MAC array.
//
// state  | meaning
// IDLE   | waiting for start; array gated off
// LOAD_W | one weight row written per cycle, rows 0..ROWS-1
// STREAM | popping activation vectors until k_len have been issued
// DRAIN  | array runs until every result has been captured and accepted
module ecmac_tile_sched
    import ecmac_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = PROD_W_DEF,
    parameter int K_W    = 16,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [K_W-1:0]          k_len,
    output logic                    busy,
    output logic                    done,
    output logic                    w_load,
    output logic [$clog2(ROWS)-1:0] w_row,
    output logic                    act_rd_en,
    input  logic                    act_empty,
    output logic                    array_en,
    input  logic [COLS*ACC_W-1:0]   col_psum,
    input  logic [COLS*PROD_W-1:0]  col_err_prod,
    input  logic [COLS-1:0]         col_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS*ACC_W-1:0]   out_data,
    output logic [CNT_W-1:0]        err_count
);

    localparam int              RW       = $clog2(ROWS);
    localparam int              DEPTH    = ROWS + COLS - 1;
    localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ecmac_state_t          state, state_nxt;
    logic [K_W-1:0]        k_reg, issued, received;
    logic [RW-1:0]         w_row_q;
    logic [DEPTH-1:0]      vld_sr;
    logic                  stall, capture, start_run, start_nop;
    logic [COLS*ACC_W-1:0] res;
    logic [CNT_W:0]        err_sum;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        ecmac_col_comp #(
            .ACC_W  (ACC_W),
            .PROD_W (PROD_W)
        ) u_comp (
            .psum     (col_psum[c*ACC_W +: ACC_W]),
            .err_prod (col_err_prod[c*PROD_W +: PROD_W]),
            .err      (col_err[c]),
            .res      (res[c*ACC_W +: ACC_W])
        );
    end

    assign stall     = out_valid & ~out_ready;
    assign busy      = (state != IDLE);
    assign w_load    = (state == LOAD_W);
    assign w_row     = w_row_q;
    assign array_en  = ((state == STREAM) || (state == DRAIN)) && !stall;
    assign act_rd_en = (state == STREAM) && !act_empty && !stall && (issued < k_reg);
    // Bubbles shift through as zeros, so a set top bit always means a real result.
    assign capture   = array_en && vld_sr[DEPTH-1];
    assign start_run = (state == IDLE) && start && (k_len != '0);
    assign start_nop = (state == IDLE) && start && (k_len == '0);
    assign err_sum   = {1'b0, err_count} + (CNT_W+1)'(popcount(POP_MAX_W'(col_err)));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_run) state_nxt = LOAD_W;
            LOAD_W:  if (!stall && w_row_q == ROW_LAST) state_nxt = STREAM;
            STREAM:  if (!stall && issued == k_reg) state_nxt = DRAIN;
            DRAIN:   if (!stall && received == k_reg) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_reg     <= '0;
            issued    <= '0;
            received  <= '0;
            w_row_q   <= '0;
            vld_sr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err_count <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= start_nop || ((state == DRAIN) && (state_nxt == IDLE));
            if (start_run) begin
                k_reg     <= k_len;
                issued    <= '0;
                received  <= '0;
                vld_sr    <= '0;
                err_count <= '0;
            end
            if (w_load && !stall) begin
                w_row_q <= (w_row_q == ROW_LAST) ? '0 : w_row_q + 1'b1;
            end
            if (act_rd_en) begin
                issued <= issued + 1'b1;
            end
            if (array_en) begin
                vld_sr <= {vld_sr[DEPTH-2:0], act_rd_en};
            end
            if (capture) begin
                received  <= received + 1'b1;
                out_data  <= res;
                out_valid <= 1'b1;
                err_count <= err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ecmac_tile_sched.sv
// Directed bench for ecmac_tile_sched: a small tile model feeds the bottom row and a scoreboard checks results.
module tb_ecmac_tile_sched;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int ACC_W  = 24;
    localparam int PROD_W = 16;
    localparam int K_W    = 16;
    localparam int CNT_W  = 16;
    localparam int RW     = $clog2(ROWS);
    localparam int DEPTH  = ROWS + COLS - 1;
    localparam int NVEC   = 128;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [K_W-1:0]         k_len;
    logic                   busy, done, w_load, act_rd_en, act_empty, array_en;
    logic [RW-1:0]          w_row;
    logic [COLS*ACC_W-1:0]  col_psum;
    logic [COLS*PROD_W-1:0] col_err_prod;
    logic [COLS-1:0]        col_err;
    logic                   out_valid, out_ready;
    logic [COLS*ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]       err_count;

    ecmac_tile_sched #(
        .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .PROD_W(PROD_W), .K_W(K_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy), .done(done),
        .w_load(w_load), .w_row(w_row), .act_rd_en(act_rd_en), .act_empty(act_empty),
        .array_en(array_en), .col_psum(col_psum), .col_err_prod(col_err_prod), .col_err(col_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err_count(err_count)
    );

    initial forever #5 clk = ~clk;

    // Per-vector stimulus tables, indexed by issue order.
    logic [ACC_W-1:0]  psum_tab [NVEC];
    logic [PROD_W-1:0] prod_tab [NVEC];
    logic [COLS-1:0]   err_tab  [NVEC];

    logic [COLS*ACC_W-1:0] sb_q  [$];
    logic [COLS*ACC_W-1:0] log_q [$];
    int pipe [DEPTH] = '{default: -1};
    int vid_next = 0;

    int total = 0, bad = 0, cyc = 0;
    int wl_cnt, rd_cnt, res_cnt, done_cnt, done_cyc, first_pop, last_pop, first_val, last_acc;
    logic busy_at_done, busy_seen, stall_chk = 1'b0;
    logic [COLS*ACC_W-1:0] snap;

    function automatic logic [ACC_W-1:0] lane_psum(int id, int c);
        return (c == 0) ? psum_tab[id] : ACC_W'(id * 16 + c);
    endfunction

    function automatic logic [PROD_W-1:0] lane_prod(int id, int c);
        return (c == 0) ? prod_tab[id] : PROD_W'(16 + c);
    endfunction

    function automatic logic [COLS*ACC_W-1:0] exp_vec(int id);
        logic [COLS*ACC_W-1:0] v;
        logic [ACC_W-1:0] p;
        v = '0;
        for (int c = 0; c < COLS; c++) begin
            p = lane_psum(id, c);
            if (err_tab[id][c]) p = p + ACC_W'(lane_prod(id, c));
            v[c*ACC_W +: ACC_W] = p;
        end
        return v;
    endfunction

    // Tile model: a vector popped now reaches the deskewed bottom row after DEPTH enabled cycles.
    always_comb begin
        col_psum     = '0;
        col_err_prod = '0;
        col_err      = '0;
        for (int c = 0; c < COLS; c++) begin
            if (pipe[DEPTH-1] >= 0) begin
                col_psum[c*ACC_W +: ACC_W]     = lane_psum(pipe[DEPTH-1], c);
                col_err_prod[c*PROD_W +: PROD_W] = lane_prod(pipe[DEPTH-1], c);
            end else begin
                col_psum[c*ACC_W +: ACC_W]     = 24'hBAD000;
                col_err_prod[c*PROD_W +: PROD_W] = 16'h0BAD;
            end
        end
        col_err = (pipe[DEPTH-1] >= 0) ? err_tab[pipe[DEPTH-1]] : '1;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= -1;
        end else if (array_en) begin
            for (int i = DEPTH - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            if (act_rd_en) begin
                pipe[0] <= vid_next;
                sb_q.push_back(exp_vec(vid_next));
                vid_next <= vid_next + 1;
            end else begin
                pipe[0] <= -1;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [COLS*ACC_W-1:0] e;
        if (!rst_n) return;
        if (busy) busy_seen = 1'b1;
        if (w_load) begin
            chk("w_row", 128'(w_row), 128'(wl_cnt));
            wl_cnt++;
        end
        if (act_rd_en) begin
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            rd_cnt++;
        end
        if (out_valid && first_val < 0) first_val = cyc;
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        if (stall_chk) begin
            chk("stall_data_hold", 128'(out_data), 128'(snap));
            chk("stall_array_en", 128'(array_en), 128'(0));
            chk("stall_rd_en", 128'(act_rd_en), 128'(0));
            chk("stall_valid", 128'(out_valid), 128'(1));
        end
        if (out_valid && out_ready) begin
            res_cnt++;
            last_acc = cyc;
            log_q.push_back(out_data);
            chk("sb_underflow", 128'(sb_q.size() == 0), 128'(0));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("out_data", 128'(out_data), 128'(e));
            end
        end
    endtask

    // Inputs are set just after a falling edge; the monitor samples 1 time unit later.
    task automatic tick();
        #1;
        cyc++;
        monitor();
        @(negedge clk);
    endtask

    task automatic clear_stats();
        wl_cnt = 0; rd_cnt = 0; res_cnt = 0; done_cnt = 0; done_cyc = -1;
        first_pop = -1; last_pop = -1; first_val = -1; last_acc = -1;
        busy_at_done = 1'bx; busy_seen = 1'b0;
        log_q.delete();
    endtask

    task automatic kick(input int k);
        start = 1'b1;
        k_len = K_W'(k);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            tick();
            n++;
        end
        chk("done_seen", 128'(done_cnt != 0), 128'(1));
        repeat (3) tick();
    endtask

    task automatic set_vec(input int off, input logic [ACC_W-1:0] ps,
                           input logic [PROD_W-1:0] pr, input logic [COLS-1:0] er);
        psum_tab[vid_next + off] = ps;
        prod_tab[vid_next + off] = pr;
        err_tab[vid_next + off]  = er;
    endtask

    initial begin
        int n, sc, base;
        logic [COLS*ACC_W-1:0] r;

        for (int i = 0; i < NVEC; i++) begin
            psum_tab[i] = ACC_W'(i * 16);
            prod_tab[i] = PROD_W'(32 + i);
            err_tab[i]  = '0;
        end
        rst_n = 1'b0; start = 1'b0; k_len = '0; act_empty = 1'b0; out_ready = 1'b1;
        clear_stats();
        repeat (2) tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_w_load", 128'(w_load), 128'(0));
        chk("rst_w_row", 128'(w_row), 128'(0));
        chk("rst_rd_en", 128'(act_rd_en), 128'(0));
        chk("rst_array_en", 128'(array_en), 128'(0));
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_data", 128'(out_data), 128'(0));
        chk("rst_err_count", 128'(err_count), 128'(0));
        rst_n = 1'b1;
        tick();

        // Plain tile, no errors, no backpressure.
        clear_stats();
        kick(3);
        wait_done();
        chk("t1_wload_cycles", 128'(wl_cnt), 128'(ROWS));
        chk("t1_pops", 128'(rd_cnt), 128'(3));
        chk("t1_results", 128'(res_cnt), 128'(3));
        chk("t1_latency", 128'(first_val - first_pop), 128'(DEPTH + 1));
        chk("t1_done_count", 128'(done_cnt), 128'(1));
        chk("t1_done_after_last", 128'(done_cyc - last_acc), 128'(1));
        chk("t1_busy_at_done", 128'(busy_at_done), 128'(0));
        chk("t1_err_count", 128'(err_count), 128'(0));
        chk("t1_sb_empty", 128'(sb_q.size()), 128'(0));

        // Compensation, wrap-around and multi-column error counting.
        clear_stats();
        base = vid_next;
        set_vec(0, 24'h000100, 16'h00FF, 4'b0001);
        set_vec(1, 24'hFFFFFF, 16'h0002, 4'b0001);
        set_vec(2, 24'h000010, 16'h0005, 4'b1010);
        kick(3);
        wait_done();
        chk("t2_results", 128'(res_cnt), 128'(3));
        r = log_q[0];
        chk("t2_lane0_comp", 128'(r[23:0]), 128'(24'h0001FF));
        chk("t2_lane1_plain", 128'(r[47:24]), 128'(base * 16 + 1));
        r = log_q[1];
        chk("t3_wrap", 128'(r[23:0]), 128'(24'h000001));
        chk("t2_err_count", 128'(err_count), 128'(4));
        chk("t2_sb_empty", 128'(sb_q.size()), 128'(0));

        // Output backpressure for five cycles.
        clear_stats();
        kick(4);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("t4_valid_seen", 128'(out_valid), 128'(1));
        snap = out_data;
        out_ready = 1'b0;
        stall_chk = 1'b1;
        repeat (5) tick();
        stall_chk = 1'b0;
        out_ready = 1'b1;
        wait_done();
        chk("t4_pops", 128'(rd_cnt), 128'(4));
        chk("t4_results", 128'(res_cnt), 128'(4));
        chk("t4_sb_empty", 128'(sb_q.size()), 128'(0));

        // Empty activation buffer for three cycles mid-stream.
        clear_stats();
        kick(5);
        n = 0;
        while (rd_cnt < 2 && n < 100) begin
            tick();
            n++;
        end
        act_empty = 1'b1;
        repeat (3) tick();
        act_empty = 1'b0;
        wait_done();
        chk("t5_pops", 128'(rd_cnt), 128'(5));
        chk("t5_results", 128'(res_cnt), 128'(5));
        chk("t5_pop_span", 128'(last_pop - first_pop), 128'(7));
        chk("t5_result_span", 128'(last_acc - first_val), 128'(7));
        chk("t5_sb_empty", 128'(sb_q.size()), 128'(0));

        // Zero-length tile.
        clear_stats();
        kick(0);
        sc = cyc;
        repeat (4) tick();
        chk("t6_zero_done_count", 128'(done_cnt), 128'(1));
        chk("t6_zero_done_cycle", 128'(done_cyc), 128'(sc + 1));
        chk("t6_zero_busy", 128'(busy_seen), 128'(0));

        // Start while busy is ignored.
        clear_stats();
        kick(2);
        repeat (2) tick();
        kick(7);
        wait_done();
        chk("t6_ign_wload", 128'(wl_cnt), 128'(ROWS));
        chk("t6_ign_pops", 128'(rd_cnt), 128'(2));
        chk("t6_ign_results", 128'(res_cnt), 128'(2));
        chk("t6_ign_done_count", 128'(done_cnt), 128'(1));

        // Reset during DRAIN.
        clear_stats();
        kick(2);
        n = 0;
        while (rd_cnt < 2 && n < 100) begin
            tick();
            n++;
        end
        repeat (2) tick();
        chk("t6_rst_pre_busy", 128'(busy), 128'(1));
        chk("t6_rst_pre_array_en", 128'(array_en), 128'(1));
        rst_n = 1'b0;
        tick();
        chk("t6_rst_outputs", 128'({busy, done, w_load, w_row, act_rd_en, array_en,
                                    out_valid, out_data, err_count}), 128'(0));
        sb_q.delete();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("t6_rst_stays_idle", 128'({busy, out_valid, done}), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
